// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES round sequencer.
package aes_pkg;

  // Round counts for the three AES key sizes.
  localparam int unsigned AES_NR_128 = 10;
  localparam int unsigned AES_NR_192 = 12;
  localparam int unsigned AES_NR_256 = 14;

  // Sequencer states. The encoding is fixed so that debug dumps stay stable.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } aes_rc_state_t;

  // A block is in flight from the load cycle through the final round.
  function automatic logic rc_is_busy(input aes_rc_state_t st);
    logic b;
    case (st)
      LOAD, ROUND, FINAL: b = 1'b1;
      default:            b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_chk.sv
// Parameter sanity and run-time invariants for the AES round sequencer.
module aes_round_ctrl_chk #(
  parameter int unsigned NR = 10,
  parameter int unsigned RW = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          ld_r,
  input logic [RW-1:0] round,
  input logic          final_round,
  input logic          out_valid
);

  // Only the three AES round counts exist, and the index must be able to hold NR.
  if (!((NR == 32'd10) || (NR == 32'd12) || (NR == 32'd14))) begin : g_bad_nr
    $fatal(1, "aes_round_ctrl: NR must be 10, 12 or 14");
  end
  if (!((64'd1 << RW) > 64'(NR))) begin : g_bad_rw
    $fatal(1, "aes_round_ctrl: round index too narrow for NR");
  end

  // Loading new text and presenting a result can never coincide.
  a_no_ld_and_valid: assert property (@(posedge clk) disable iff (rst)
    !(ld_r && out_valid));

  // The counter never runs past the last round.
  a_round_bounded: assert property (@(posedge clk) disable iff (rst)
    (round <= RW'(NR)));

  // MixColumns bypass is only selected on the last round.
  a_final_at_nr: assert property (@(posedge clk) disable iff (rst)
    final_round |-> (round == RW'(NR)));

endmodule

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES encryption datapath: drives the
// add-round-key load strobe, round index and final-round select, and holds
// the completed result against downstream backpressure.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR_128,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic          out_ready,
  output logic          ld_r,
  output logic [RW-1:0] round,
  output logic          final_round,
  output logic          busy,
  output logic          out_valid
);

  localparam logic [RW-1:0] ROUND_LAST = RW'(NR);
  localparam logic [RW-1:0] ROUND_PREV = RW'(NR - 1);
  localparam logic [RW-1:0] ROUND_ZERO = {RW{1'b0}};
  localparam logic [RW-1:0] ROUND_ONE  = RW'(1);

  aes_rc_state_t   state_q, state_d;
  logic            ld_r_q, ld_r_d;
  logic [RW-1:0]   round_q, round_d;
  logic            final_q, final_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ld is only honoured in IDLE or when DONE is being drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ld) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        state_d = ROUND;
      end
      ROUND: begin
        if (round_q == ROUND_PREV) begin
          state_d = FINAL;
        end else begin
          state_d = ROUND;
        end
      end
      FINAL: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (ld) begin
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: values for the upcoming state, registered below so no input reaches an output combinationally.
  always_comb begin
    ld_r_d  = 1'b0;
    round_d = ROUND_ZERO;
    final_d = 1'b0;
    busy_d  = rc_is_busy(state_d);
    valid_d = 1'b0;
    case (state_d)
      IDLE: begin
        round_d = ROUND_ZERO;
      end
      LOAD: begin
        ld_r_d  = 1'b1;
        round_d = ROUND_ZERO;
      end
      ROUND: begin
        // Entered from LOAD with round 0, so the first ROUND cycle shows 1.
        round_d = round_q + ROUND_ONE;
      end
      FINAL: begin
        final_d = 1'b1;
        round_d = ROUND_LAST;
      end
      DONE: begin
        valid_d = 1'b1;
        round_d = round_q;
      end
      default: begin
        round_d = ROUND_ZERO;
      end
    endcase
  end

  // Output registers; reset aborts any block in flight without a completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_r_q  <= 1'b0;
      round_q <= ROUND_ZERO;
      final_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      ld_r_q  <= ld_r_d;
      round_q <= round_d;
      final_q <= final_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign ld_r        = ld_r_q;
  assign round       = round_q;
  assign final_round = final_q;
  assign busy        = busy_q;
  assign out_valid   = valid_q;

  aes_round_ctrl_chk #(
    .NR (NR),
    .RW (RW)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .ld_r        (ld_r_q),
    .round       (round_q),
    .final_round (final_q),
    .out_valid   (valid_q)
  );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed self-checking bench for aes_round_ctrl (NR=10 and NR=14 builds).
module tb_aes_round_ctrl;

  logic       clk;
  logic       rst;
  logic       ld, out_ready;
  logic       ld_r, final_round, busy, out_valid;
  logic [3:0] round;
  logic       ld14, out_ready14;
  logic       ld_r14, final14, busy14, valid14;
  logic [3:0] round14;

  int checks;
  int errors;

  aes_round_ctrl #(.NR(10), .RW(4)) dut (
    .clk(clk), .rst(rst), .ld(ld), .out_ready(out_ready),
    .ld_r(ld_r), .round(round), .final_round(final_round),
    .busy(busy), .out_valid(out_valid)
  );

  aes_round_ctrl #(.NR(14), .RW(4)) dut14 (
    .clk(clk), .rst(rst), .ld(ld14), .out_ready(out_ready14),
    .ld_r(ld_r14), .round(round14), .final_round(final14),
    .busy(busy14), .out_valid(valid14)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect10(input string tag, input int e_ldr, input int e_rnd,
                          input int e_fin, input int e_bsy, input int e_vld);
    check({tag, ".ld_r"},        32'(ld_r),        32'(e_ldr));
    check({tag, ".round"},       32'(round),       32'(e_rnd));
    check({tag, ".final_round"}, 32'(final_round), 32'(e_fin));
    check({tag, ".busy"},        32'(busy),        32'(e_bsy));
    check({tag, ".out_valid"},   32'(out_valid),   32'(e_vld));
  endtask

  task automatic expect14(input string tag, input int e_ldr, input int e_rnd,
                          input int e_fin, input int e_bsy, input int e_vld);
    check({tag, ".ld_r"},        32'(ld_r14),  32'(e_ldr));
    check({tag, ".round"},       32'(round14), 32'(e_rnd));
    check({tag, ".final_round"}, 32'(final14), 32'(e_fin));
    check({tag, ".busy"},        32'(busy14),  32'(e_bsy));
    check({tag, ".out_valid"},   32'(valid14), 32'(e_vld));
  endtask

  // One complete block on the NR=10 instance, out_ready assumed high, starting from IDLE.
  task automatic run_single(input string tag);
    ld = 1'b1;
    tick();
    ld = 1'b0;
    expect10($sformatf("%s_c0", tag), 1, 0, 0, 1, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      expect10($sformatf("%s_c%0d", tag, k), 0, k, (k == 10) ? 1 : 0, 1, 0);
    end
    tick();
    expect10($sformatf("%s_c11", tag), 0, 10, 0, 0, 1);
    tick();
    expect10($sformatf("%s_idle", tag), 0, 0, 0, 0, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ld = 1'b0;
    out_ready = 1'b1;
    ld14 = 1'b0;
    out_ready14 = 1'b1;

    // Reset values.
    tick();
    tick();
    expect10("rst10", 0, 0, 0, 0, 0);
    expect14("rst14", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    expect10("post_rst", 0, 0, 0, 0, 0);

    // Single block.
    run_single("single");

    // Backpressure: hold DONE for 5 cycles.
    out_ready = 1'b0;
    ld = 1'b1;
    tick();
    ld = 1'b0;
    for (int k = 1; k <= 11; k++) tick();
    expect10("bp_hold0", 0, 10, 0, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      expect10($sformatf("bp_hold%0d", k), 0, 10, 0, 0, 1);
    end
    out_ready = 1'b1;
    tick();
    expect10("bp_release", 0, 0, 0, 0, 0);

    // Back-to-back: three blocks with ld and out_ready held high.
    ld = 1'b1;
    tick();
    for (int c = 0; c < 36; c++) begin
      check($sformatf("b2b_ldr_c%0d", c), 32'(ld_r), (c % 12 == 0) ? 32'd1 : 32'd0);
      check($sformatf("b2b_noidle_c%0d", c), 32'(busy | out_valid), 32'd1);
      check($sformatf("b2b_round_c%0d", c), 32'(round),
            (c % 12 == 11) ? 32'd10 : 32'(c % 12));
      if (c < 35) tick();
    end
    ld = 1'b0;
    tick();
    expect10("b2b_end", 0, 0, 0, 0, 0);

    // Ignored request mid-block.
    ld = 1'b1;
    tick();
    ld = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    check("ign_at4", 32'(round), 32'd4);
    ld = 1'b1;
    tick();
    ld = 1'b0;
    for (int k = 5; k <= 10; k++) begin
      expect10($sformatf("ign_c%0d", k), 0, k, (k == 10) ? 1 : 0, 1, 0);
      tick();
    end
    expect10("ign_c11", 0, 10, 0, 0, 1);
    tick();
    expect10("ign_idle", 0, 0, 0, 0, 0);
    tick();
    expect10("ign_idle2", 0, 0, 0, 0, 0);

    // Asynchronous reset at round 6.
    ld = 1'b1;
    tick();
    ld = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    check("ar_at6", 32'(round), 32'd6);
    #1 rst = 1'b1;
    #1;
    expect10("ar_abort", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    run_single("ar_after");

    // NR=14 build.
    ld14 = 1'b1;
    tick();
    ld14 = 1'b0;
    expect14("nr14_c0", 1, 0, 0, 1, 0);
    for (int k = 1; k <= 14; k++) begin
      tick();
      expect14($sformatf("nr14_c%0d", k), 0, k, (k == 14) ? 1 : 0, 1, 0);
    end
    tick();
    expect14("nr14_c15", 0, 14, 0, 0, 1);
    tick();
    expect14("nr14_idle", 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
